// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage for the 16-bit von Neumann CPU. Holds the
//            program counter and fetches one word at a time from instruction
//            memory over a req/ack handshake. Each word is presented to decode
//            through a one-entry valid/ready register. The stage supports jump
//            redirection with flush, and a halt level that stops new fetches.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            rom_req/rom_addr             - fetch request and address (= pc)
//            rom_ack/rom_data             - same-cycle memory response
//            instr/instr_pc/instr_valid   - buffered entry to decode
//            instr_ready                  - decode accepts the entry
//            jump/jump_target             - redirect pc and flush the entry
//            halt                         - blocks starting a new fetch
//            pc                           - current fetch pc
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t r_state;

  // The address is always the live pc. It changes during a request only when
  // a jump redirects the pc.
  assign rom_addr = pc;

  // rom_req is registered alongside the state, so it is high exactly while
  // the state is FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      pc          <= RESET_PC;
      rom_req     <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (jump) begin
      // A jump overrides everything. A same-cycle ack is dropped, and a
      // same-cycle transfer is treated as already taken by decode.
      pc          <= jump_target;
      instr_valid <= 1'b0;
      r_state     <= halt ? S_IDLE : S_FETCH;
      rom_req     <= ~halt;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!halt) begin
            r_state <= S_FETCH;
            rom_req <= 1'b1;
          end
        end
        S_FETCH: begin
          // Halt is ignored here, so a started fetch always lands in HOLD.
          if (rom_ack) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + C_PC_ONE;
            r_state     <= S_HOLD;
            rom_req     <= 1'b0;
          end
        end
        S_HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            r_state     <= halt ? S_IDLE : S_FETCH;
            rom_req     <= ~halt;
          end
        end
        default: begin
          r_state <= S_IDLE;
          rom_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural model tracks pc,
//            the outstanding request and the output entry. Directed scenarios
//            and a randomized run are compared against that model and against
//            fixed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_req, rom_ack;
  logic [15:0] rom_addr, rom_data;
  logic [15:0] instr, instr_pc, pc;
  logic        instr_valid, instr_ready;
  logic        jump, halt;
  logic [15:0] jump_target;
  logic        ack_en;

  // Second instance with RESET_PC at the top of the address space.
  logic        rom_req2, rom_ack2, instr_valid2;
  logic [15:0] rom_addr2, rom_data2, instr2, instr_pc2, pc2;

  int checks   = 0;
  int failures = 0;

  // Model state.
  logic [15:0] m_pc, m_instr, m_ipc;
  logic        m_req, m_valid;

  always #5 clk = ~clk;

  // Memory returns 0xA000+addr. Ack is gated by a bench-controlled enable.
  assign rom_ack   = rom_req & ack_en;
  assign rom_data  = 16'hA000 + rom_addr;
  assign rom_ack2  = rom_req2;
  assign rom_data2 = 16'hA000 + rom_addr2;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump(jump),
    .jump_target(jump_target), .halt(halt), .pc(pc)
  );

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .rom_req(rom_req2), .rom_addr(rom_addr2),
    .rom_ack(rom_ack2), .rom_data(rom_data2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready), .jump(jump),
    .jump_target(jump_target), .halt(halt), .pc(pc2)
  );

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
    m_req = 1'b0; m_valid = 1'b0;
  endtask

  // One clock edge of the fetch rules. It is evaluated from the inputs present
  // at the edge.
  task automatic model_edge();
    if (jump) begin
      m_pc = jump_target; m_valid = 1'b0; m_req = ~halt;
    end else if (m_req) begin
      if (ack_en) begin
        m_instr = 16'hA000 + m_pc; m_ipc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 16'd1; m_req = 1'b0;
      end
    end else if (m_valid) begin
      if (instr_ready) begin
        m_valid = 1'b0; m_req = ~halt;
      end
    end else begin
      m_req = ~halt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; jump = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    ack_en = 1'b0; jump_target = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    halt = 1'b1;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    checks++; if (rom_addr !== 16'h0000) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0000", rom_addr); end
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL reset_rom_req got=%b exp=0", rom_req); end
    checks++; if ({instr, instr_pc} !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0000/0000", instr, instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (pc2 !== 16'hFFFF) begin failures++; $display("FAIL reset_pc2 got=%h exp=ffff", pc2); end
    tick();
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL reset_halt_idle got=%b exp=0", rom_req); end
    halt = 1'b0;
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0000) begin failures++; $display("FAIL reset_first_fetch got=%b/%h exp=1/0000", rom_req, rom_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] seen[$];
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (instr_valid !== (k % 2 == 0)) begin failures++; $display("FAIL stream_valid_cycle%0d got=%b exp=%b", k, instr_valid, (k % 2 == 0)); end
      if (instr_valid && instr_ready) seen.push_back({instr_pc, instr});
    end
    checks++; if (seen.size() < 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", seen.size()); end
    else begin
      checks++; if (seen[0] !== 32'h0000_A000) begin failures++; $display("FAIL stream_e0 got=%h exp=0000a000", seen[0]); end
      checks++; if (seen[1] !== 32'h0001_A001) begin failures++; $display("FAIL stream_e1 got=%h exp=0001a001", seen[1]); end
      checks++; if (seen[2] !== 32'h0002_A002) begin failures++; $display("FAIL stream_e2 got=%h exp=0002a002", seen[2]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({instr_valid, instr_pc, instr, rom_req} !== {1'b1, 16'h0000, 16'hA000, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b pc=%h i=%h req=%b exp v=1 pc=0000 i=a000 req=0", k, instr_valid, instr_pc, instr, rom_req);
      end
      tick();
    end
    instr_ready = 1'b1;
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL bp_ready_cycle_req got=%b exp=0", rom_req); end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0001) begin failures++; $display("FAIL bp_next_fetch got=%b/%h exp=1/0001", rom_req, rom_addr); end
  endtask

  task automatic test_jump();
    bit found = 1'b0;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (m_req && m_pc == 16'h0003) found = 1'b1;
    end
    checks++; if (!found || rom_addr !== 16'h0003 || rom_req !== 1'b1) begin failures++; $display("FAIL jump_reach got=%b/%h exp=1/0003", rom_req, rom_addr); end
    jump = 1'b1; jump_target = 16'h0100;
    tick();
    jump = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL jump_flush got=%b exp=0", instr_valid); end
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0100) begin failures++; $display("FAIL jump_addr got=%b/%h exp=1/0100", rom_req, rom_addr); end
    tick();
    checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0100, 16'hA100}) begin failures++; $display("FAIL jump_entry got=%b/%h/%h exp=1/0100/a100", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    tick(); tick();
    checks++; if ({instr_valid2, instr_pc2, instr2} !== {1'b1, 16'hFFFF, 16'h9FFF}) begin failures++; $display("FAIL wrap_entry got=%b/%h/%h exp=1/ffff/9fff", instr_valid2, instr_pc2, instr2); end
    checks++; if (pc2 !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", pc2); end
    tick();
    checks++; if (rom_req2 !== 1'b1 || rom_addr2 !== 16'h0000) begin failures++; $display("FAIL wrap_fetch got=%b/%h exp=1/0000", rom_req2, rom_addr2); end
  endtask

  task automatic test_halt_jump();
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b0;
    tick(); tick();
    halt = 1'b1; instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || rom_req !== 1'b0) begin failures++; $display("FAIL halt_idle got=%b/%b exp=0/0", instr_valid, rom_req); end
    tick();
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL halt_stay got=%b exp=0", rom_req); end
    jump = 1'b1; jump_target = 16'h0040;
    tick();
    jump = 1'b0;
    checks++; if (pc !== 16'h0040 || rom_req !== 1'b0) begin failures++; $display("FAIL halt_jump got=%h/%b exp=0040/0", pc, rom_req); end
    halt = 1'b0;
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0040) begin failures++; $display("FAIL halt_resume got=%b/%h exp=1/0040", rom_req, rom_addr); end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (m_req && m_pc == 16'h0005) found = 1'b1;
    end
    ack_en = 1'b0;
    checks++; if (!found || pc !== 16'h0005 || rom_req !== 1'b1) begin failures++; $display("FAIL midrst_reach got=%h/%b exp=0005/1", pc, rom_req); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({rom_req, instr_valid, pc} !== {1'b0, 1'b0, 16'h0000}) begin failures++; $display("FAIL midrst_async got req=%b v=%b pc=%h exp 0/0/0000", rom_req, instr_valid, pc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0000) begin failures++; $display("FAIL midrst_restart got=%b/%h exp=1/0000", rom_req, rom_addr); end
  endtask

  task automatic test_random();
    logic [65:0] got, exp;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ack_en      = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      halt        = ($urandom_range(0, 7) == 0);
      jump        = ($urandom_range(0, 9) == 0);
      jump_target = 16'($urandom);
      tick();
      got = {rom_req, rom_addr, instr_valid, instr, instr_pc, pc};
      exp = {m_req, m_pc, m_valid, m_instr, m_ipc, m_pc};
      checks++;
      if (got !== exp) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL random_cycle%0d got=%h exp=%h", k, got, exp);
      end
    end
    jump = 1'b0; halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt_jump();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit von Neumann CPU. Holds the program counter, fetches one instruction word per cycle-pair from instruction memory over a req/ack handshake, and presents it to the decode stage through a one-entry valid/ready output register. It supports jump redirection with flush and a halt input that stops new fetches.

## Interface
- ADDR_W, 16, program counter and memory address width
- DATA_W, 16, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rom_req  output  1  fetch request; address on rom_addr is valid
- rom_addr  output  ADDR_W  fetch address, equal to current pc
- rom_ack  input  1  rom_data valid for the rom_addr presented this same cycle
- rom_data  input  DATA_W  instruction word from memory
- instr  output  DATA_W  buffered instruction to decode
- instr_pc  output  ADDR_W  address instr was fetched from
- instr_valid  output  1  instr/instr_pc hold a valid entry
- instr_ready  input  1  decode accepts entry this cycle
- jump  input  1  redirect request, single-cycle qualifier
- jump_target  input  ADDR_W  new pc when jump=1
- halt  input  1  level; when high, no new fetch is started
- pc  output  ADDR_W  current fetch pc

## Operation
- States: IDLE, FETCH, HOLD. Reset state IDLE.
- IDLE: rom_req=0. Next state is FETCH if halt=0, otherwise IDLE.
- FETCH: rom_req=1, rom_addr=pc, held stable until rom_ack.
  - On rom_ack=1: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, next state HOLD.
  - With rom_ack=0: remain in FETCH.
- HOLD: rom_req=0; entry held stable while instr_valid=1 and instr_ready=0.
  - On transfer (instr_valid & instr_ready): instr_valid<=0; next state FETCH if halt=0, else IDLE.
- Halt: sampled only on the IDLE and HOLD exits. An in-progress FETCH always completes into HOLD.
- Jump has priority over every other event, in any state:
  - pc<=jump_target and instr_valid<=0 (flush).
  - Next state is FETCH if halt=0, else IDLE.
  - A rom_ack in the same cycle is discarded: pc does not increment and instr is not loaded.
  - A transfer coinciding with jump counts as completed by decode.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000. No overflow flag.
- Jump while halted: pc updates and the block stays IDLE. The next fetch uses jump_target.
- instr and instr_pc keep their last value after a transfer or flush. Only instr_valid qualifies them.

## Timing
- Reset (async assert, sync use after deassert):
  - pc=RESET_PC, rom_addr=RESET_PC, rom_req=0, instr=0, instr_pc=0, instr_valid=0.
  - State=IDLE, effective immediately on rst_n falling edge regardless of clk.
- First cycle after reset release is IDLE. rom_req rises on the following edge if halt=0.
- Fetch latency: rom_ack in cycle N -> instr_valid=1 from edge ending N; pc=old+1 from the same edge.
- Peak throughput: one instruction per 2 cycles (FETCH, HOLD with instr_ready=1).
- Backpressure: no rom_req while an entry is waiting in HOLD.
- rom_addr changes while rom_req=1 only on jump. The ROM must respond for the current address only.
- Reset mid-FETCH or mid-HOLD aborts the operation and drops any entry. No partial state survives.

## Test plan
- Reset mid-FETCH (rst_n low between edges, pc=0x0005) -> immediately rom_req=0, instr_valid=0, pc=RESET_PC=0x0000.
- ROM acks every request in the same cycle, instr_ready=1, data=0xA000+addr -> decode receives (0x0000,0xA000), (0x0001,0xA001), (0x0002,0xA002), with instr_valid high every other cycle.
- instr_ready=0 for 3 cycles after the entry (0x0000,0xA000) -> instr/instr_pc stable, rom_req=0 for all 3 cycles; next fetch at 0x0001 starts the cycle after ready rises.
- jump=1, jump_target=0x0100 in the same cycle as rom_ack for 0x0003 -> data discarded, instr_valid=0, next rom_addr=0x0100, next entry instr_pc=0x0100.
- RESET_PC=0xFFFF -> first entry instr_pc=0xFFFF, next rom_addr=0x0000.
- halt=1 while in HOLD -> after the transfer the block goes to IDLE with rom_req=0. Then jump_target=0x0040 while halted sets pc=0x0040. halt=0 -> FETCH at 0x0040.
